// File: rtl/emaxi_write_master_if.sv
// Bus bundle for emaxi_write_master: the emesh write-packet port on one side
// and the AXI4 AW/W/B write channels on the other, plus the error status.
//   master modport : the write master (drives AW/W, bready, wr_wait, status)
//   slave  modport : the packet source / AXI slave side seen by the master
interface emaxi_write_master_if #(
    parameter int IDW = 12
);
    // emesh packet side
    logic           wr_access;
    logic [103:0]   wr_packet;
    logic           wr_wait;

    // AXI write address channel
    logic [IDW-1:0] m_axi_awid;
    logic [31:0]    m_axi_awaddr;
    logic [7:0]     m_axi_awlen;
    logic [2:0]     m_axi_awsize;
    logic [1:0]     m_axi_awburst;
    logic           m_axi_awvalid;
    logic           m_axi_awready;

    // AXI write data channel
    logic [IDW-1:0] m_axi_wid;
    logic [31:0]    m_axi_wdata;
    logic [3:0]     m_axi_wstrb;
    logic           m_axi_wlast;
    logic           m_axi_wvalid;
    logic           m_axi_wready;

    // AXI write response channel
    logic [IDW-1:0] m_axi_bid;
    logic [1:0]     m_axi_bresp;
    logic           m_axi_bvalid;
    logic           m_axi_bready;

    // error status
    logic           err_pulse;
    logic [7:0]     err_count;

    modport master (
        input  wr_access, wr_packet,
        output wr_wait,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output err_pulse, err_count
    );

    modport slave (
        output wr_access, wr_packet,
        input  wr_wait,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  err_pulse, err_count
    );
endinterface

// File: rtl/emaxi_write_master.sv
// emaxi_write_master: turns single emesh write packets into AXI4 write bursts
// (one AW, one or two W beats) and completes each on the B channel. Only one
// transaction is in flight; wr_wait holds off the packet source meanwhile.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - emaxi_write_master_if.master: packet input, AW/W/B channels,
//          err_pulse (one cycle per errored response), err_count (saturating)
module emaxi_write_master #(
    parameter int             IDW    = 12,
    parameter logic [IDW-1:0] AXI_ID = '0
) (
    input  logic clk,
    input  logic rst,
    emaxi_write_master_if.master bus
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [7:0]  awlen_q, awlen_d;
    logic [2:0]  awsize_q, awsize_d;
    logic [31:0] data0_q, data0_d;    // beat 0 payload
    logic [31:0] data1_q, data1_d;    // beat 1 payload (double writes only)
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        beat_q, beat_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        err_pulse_q, err_pulse_d;
    logic [7:0]  err_count_q, err_count_d;

    // packet fields
    logic        pkt_write;
    logic [1:0]  pkt_dm;
    logic [31:0] pkt_dst, pkt_data, pkt_src;
    logic [4:0]  unused_ctrlmode;

    assign pkt_write       = bus.wr_packet[0];
    assign pkt_dm          = bus.wr_packet[2:1];
    assign unused_ctrlmode = bus.wr_packet[7:3];
    assign pkt_dst         = bus.wr_packet[39:8];
    assign pkt_data        = bus.wr_packet[71:40];
    assign pkt_src         = bus.wr_packet[103:72];

    logic accept, aw_hs, w_hs, w_is_last, b_hs, b_err;

    assign accept    = bus.wr_access && (state_q == IDLE) && pkt_write;
    assign aw_hs     = awvalid_q && bus.m_axi_awready;
    assign w_hs      = wvalid_q && bus.m_axi_wready;
    // the final beat is beat 0 for single-beat bursts, beat 1 for doubles
    assign w_is_last = (beat_q == awlen_q[0]);
    assign b_hs      = (state_q == RESP) && bus.m_axi_bvalid;
    assign b_err     = (bus.m_axi_bresp != 2'b00) || (bus.m_axi_bid != AXI_ID);

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        awsize_d    = awsize_q;
        data0_d     = data0_q;
        data1_d     = data1_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        beat_d      = beat_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = XFER;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    beat_d    = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    awlen_d   = 8'd0;
                    data1_d   = pkt_src;
                    case (pkt_dm)
                        2'd0: begin
                            awaddr_d = pkt_dst;
                            awsize_d = 3'd0;
                            wstrb_d  = 4'b0001 << pkt_dst[1:0];
                            data0_d  = {4{pkt_data[7:0]}};
                        end
                        2'd1: begin
                            awaddr_d = {pkt_dst[31:1], 1'b0};
                            awsize_d = 3'd1;
                            wstrb_d  = 4'b0011 << {pkt_dst[1], 1'b0};
                            data0_d  = {2{pkt_data[15:0]}};
                        end
                        2'd2: begin
                            awaddr_d = {pkt_dst[31:2], 2'b00};
                            awsize_d = 3'd2;
                            wstrb_d  = 4'hF;
                            data0_d  = pkt_data;
                        end
                        default: begin
                            // 64-bit write as a two-beat 32-bit INCR burst
                            awaddr_d = {pkt_dst[31:3], 3'b000};
                            awsize_d = 3'd2;
                            awlen_d  = 8'd1;
                            wstrb_d  = 4'hF;
                            data0_d  = pkt_data;
                        end
                    endcase
                end
            end

            XFER: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    if (w_is_last) begin
                        wvalid_d = 1'b0;
                        w_done_d = 1'b1;
                    end else begin
                        beat_d = 1'b1;
                    end
                end
                // AW and W finish independently; move on once both are done,
                // counting handshakes that happen this very cycle
                if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && w_is_last))) begin
                    state_d = RESP;
                end
            end

            RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                    if (b_err) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awsize_q    <= '0;
            data0_q     <= '0;
            data1_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            beat_q      <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awsize_q    <= awsize_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            beat_q      <= beat_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.wr_wait       = (state_q != IDLE);

    assign bus.m_axi_awid    = AXI_ID;
    assign bus.m_axi_awaddr  = awaddr_q;
    assign bus.m_axi_awlen   = awlen_q;
    assign bus.m_axi_awsize  = awsize_q;
    assign bus.m_axi_awburst = 2'b01;
    assign bus.m_axi_awvalid = awvalid_q;

    assign bus.m_axi_wid     = AXI_ID;
    assign bus.m_axi_wdata   = beat_q ? data1_q : data0_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wlast   = wvalid_q && w_is_last;
    assign bus.m_axi_wvalid  = wvalid_q;

    assign bus.m_axi_bready  = (state_q == RESP);

    assign bus.err_pulse     = err_pulse_q;
    assign bus.err_count     = err_count_q;

endmodule

// File: tb/tb_emaxi_write_master.sv
module tb_emaxi_write_master;

    localparam int             IDW    = 12;
    localparam logic [IDW-1:0] AXI_ID = 12'h3A5;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } aw_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    emaxi_write_master_if #(.IDW(IDW)) bus ();

    emaxi_write_master #(.IDW(IDW), .AXI_ID(AXI_ID)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    aw_t exp_aw[$];
    w_t  exp_w[$];
    bit  exp_b[$];

    int tests = 0;
    int fails = 0;

    int             aw_delay = 0;
    int             w_delay  = 0;
    int             b_delay  = 0;
    logic [1:0]     cfg_bresp = 2'b00;
    logic [IDW-1:0] cfg_bid   = AXI_ID;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- AXI slave responders ----------------
    initial begin
        int cnt;
        cnt = 0;
        bus.m_axi_awready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.m_axi_awvalid && !rst) begin
                if (cnt >= aw_delay) bus.m_axi_awready = 1'b1;
                else begin
                    bus.m_axi_awready = 1'b0;
                    cnt++;
                end
            end else begin
                bus.m_axi_awready = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        bus.m_axi_wready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.m_axi_wvalid && !rst) begin
                if (cnt >= w_delay) bus.m_axi_wready = 1'b1;
                else begin
                    bus.m_axi_wready = 1'b0;
                    cnt++;
                end
            end else begin
                bus.m_axi_wready = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        bus.m_axi_bvalid = 1'b0;
        bus.m_axi_bresp  = 2'b00;
        bus.m_axi_bid    = '0;
        forever begin
            @(negedge clk);
            if (bus.m_axi_bready && !rst) begin
                if (cnt >= b_delay) begin
                    bus.m_axi_bvalid = 1'b1;
                    bus.m_axi_bresp  = cfg_bresp;
                    bus.m_axi_bid    = cfg_bid;
                end else begin
                    bus.m_axi_bvalid = 1'b0;
                    cnt++;
                end
            end else begin
                bus.m_axi_bvalid = 1'b0;
                cnt = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        aw_t         a;
        w_t          w;
        bit          e;
        bit          hold_aw, hold_w, aw_seen, wl_seen, pend, pend_err;
        logic [42:0] aw_save;
        logic [36:0] w_save;
        int          model_cnt;
        hold_aw = 0; hold_w = 0; aw_seen = 0; wl_seen = 0; pend = 0; pend_err = 0;
        aw_save = '0; w_save = '0; model_cnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold_aw = 0; hold_w = 0; aw_seen = 0; wl_seen = 0; pend = 0; model_cnt = 0;
            end else begin
                // error status reflects the response handshake of the previous cycle
                check("err_pulse", 64'(bus.err_pulse), pend ? 64'(pend_err) : 64'd0);
                check("err_count", 64'(bus.err_count), 64'(model_cnt));
                pend = 0;

                if (hold_aw) begin
                    check("aw_valid_held", 64'(bus.m_axi_awvalid), 64'd1);
                    check("aw_stable", 64'({bus.m_axi_awaddr, bus.m_axi_awlen, bus.m_axi_awsize}), 64'(aw_save));
                end
                hold_aw = 0;
                if (bus.m_axi_awvalid) begin
                    if (bus.m_axi_awready) begin
                        if (exp_aw.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
                        else begin
                            a = exp_aw.pop_front();
                            check("awaddr", 64'(bus.m_axi_awaddr), 64'(a.addr));
                            check("awlen", 64'(bus.m_axi_awlen), 64'(a.len));
                            check("awsize", 64'(bus.m_axi_awsize), 64'(a.size));
                            check("awburst", 64'(bus.m_axi_awburst), 64'd1);
                            check("awid", 64'(bus.m_axi_awid), 64'(AXI_ID));
                        end
                        aw_seen = 1;
                    end else begin
                        hold_aw = 1;
                        aw_save = {bus.m_axi_awaddr, bus.m_axi_awlen, bus.m_axi_awsize};
                    end
                end

                if (hold_w) begin
                    check("w_valid_held", 64'(bus.m_axi_wvalid), 64'd1);
                    check("w_stable", 64'({bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_wlast}), 64'(w_save));
                end
                hold_w = 0;
                if (bus.m_axi_wvalid) begin
                    if (bus.m_axi_wready) begin
                        if (exp_w.size() == 0) check("w_unexpected", 64'd1, 64'd0);
                        else begin
                            w = exp_w.pop_front();
                            check("wdata", 64'(bus.m_axi_wdata), 64'(w.data));
                            check("wstrb", 64'(bus.m_axi_wstrb), 64'(w.strb));
                            check("wlast", 64'(bus.m_axi_wlast), 64'(w.last));
                            check("wid", 64'(bus.m_axi_wid), 64'(AXI_ID));
                            if (w.last) wl_seen = 1;
                        end
                    end else begin
                        hold_w = 1;
                        w_save = {bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_wlast};
                    end
                end

                if (bus.m_axi_bready) begin
                    check("resp_after_aw_and_w", 64'(aw_seen && wl_seen), 64'd1);
                    check("wr_wait_in_resp", 64'(bus.wr_wait), 64'd1);
                    if (bus.m_axi_bvalid) begin
                        if (exp_b.size() == 0) check("b_unexpected", 64'd1, 64'd0);
                        else begin
                            e = exp_b.pop_front();
                            pend = 1;
                            pend_err = e;
                            if (e && model_cnt < 255) model_cnt++;
                        end
                        aw_seen = 0;
                        wl_seen = 0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_expect(input logic [1:0] dm, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] s);
        aw_t ea;
        w_t  ew;
        ea.len = 8'd0;
        case (dm)
            2'd0: begin
                ea.addr = a; ea.size = 3'd0;
                ew.data = 32'(d[7:0]) * 32'h0101_0101;
                ew.strb = 4'(1 << (a % 4));
            end
            2'd1: begin
                ea.addr = a & ~32'h1; ea.size = 3'd1;
                ew.data = 32'(d[15:0]) * 32'h0001_0001;
                ew.strb = 4'(3 << (a & 32'h2));
            end
            2'd2: begin
                ea.addr = a & ~32'h3; ea.size = 3'd2;
                ew.data = d; ew.strb = 4'hF;
            end
            default: begin
                ea.addr = a & ~32'h7; ea.size = 3'd2; ea.len = 8'd1;
                ew.data = d; ew.strb = 4'hF; ew.last = 1'b0;
                exp_w.push_back(ew);
                ew.data = s;
            end
        endcase
        ew.last = 1'b1;
        exp_aw.push_back(ea);
        exp_w.push_back(ew);
    endtask

    task automatic send(input logic [1:0] dm, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] s, input int ad, input int wd, input int bd,
                        input logic [1:0] bresp, input logic [IDW-1:0] bid);
        int t;
        aw_delay = ad; w_delay = wd; b_delay = bd;
        cfg_bresp = bresp; cfg_bid = bid;
        check("wr_wait_idle_before_send", 64'(bus.wr_wait), 64'd0);
        push_expect(dm, a, d, s);
        exp_b.push_back((bresp != 2'b00) || (bid != AXI_ID));
        bus.wr_packet = {s, d, a, 5'($urandom_range(0, 31)), dm, 1'b1};
        bus.wr_access = 1'b1;
        @(negedge clk);
        bus.wr_access = 1'b0;
        t = 0;
        while ((exp_b.size() != 0 || bus.wr_wait) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            check("transaction_timeout", 64'd1, 64'd0);
            exp_aw.delete(); exp_w.delete(); exp_b.delete();
        end
        $display("[TB] txn dm=%0d addr=%h data=%h src=%h bresp=%0d bid=%h", dm, a, d, s, bresp, bid);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] dm;
        bus.wr_access = 1'b0;
        bus.wr_packet = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wr_wait", 64'(bus.wr_wait), 64'd0);
        check("rst_awvalid", 64'(bus.m_axi_awvalid), 64'd0);
        check("rst_wvalid", 64'(bus.m_axi_wvalid), 64'd0);
        check("rst_wlast", 64'(bus.m_axi_wlast), 64'd0);
        check("rst_bready", 64'(bus.m_axi_bready), 64'd0);
        check("rst_err_pulse", 64'(bus.err_pulse), 64'd0);
        check("rst_err_count", 64'(bus.err_count), 64'd0);
        check("rst_fields", 64'({bus.m_axi_awaddr, bus.m_axi_awlen, bus.m_axi_awsize, bus.m_axi_wstrb}), 64'd0);
        check("rst_wdata", 64'(bus.m_axi_wdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed cases
        send(2'd2, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 2'b00, AXI_ID);
        send(2'd0, 32'h0000_2003, 32'h0000_00AB, 32'h0, 0, 0, 0, 2'b00, AXI_ID);
        send(2'd1, 32'h0000_2002, 32'h0000_1234, 32'h0, 0, 0, 0, 2'b00, AXI_ID);
        send(2'd3, 32'h0000_3004, 32'h1111_1111, 32'h2222_2222, 0, 0, 0, 2'b00, AXI_ID);
        send(2'd2, 32'h0000_4000, 32'hCAFE_0001, 32'h0, 3, 0, 0, 2'b00, AXI_ID);
        send(2'd2, 32'h0000_4004, 32'hCAFE_0002, 32'h0, 0, 3, 0, 2'b00, AXI_ID);
        send(2'd3, 32'h0000_5008, 32'hAAAA_0001, 32'hBBBB_0002, 0, 3, 2, 2'b00, AXI_ID);
        send(2'd2, 32'h0000_6000, 32'h0BAD_0BAD, 32'h0, 0, 0, 0, 2'b10, AXI_ID);
        send(2'd2, 32'h0000_6004, 32'h0BAD_0BAD, 32'h0, 0, 0, 0, 2'b00, AXI_ID ^ 12'h001);

        // write=0 packets are ignored
        bus.wr_packet = {32'h1, 32'h2, 32'h7000, 5'd0, 2'd2, 1'b0};
        bus.wr_access = 1'b1;
        @(negedge clk);
        bus.wr_access = 1'b0;
        check("drop_wr_wait", 64'(bus.wr_wait), 64'd0);
        check("drop_awvalid", 64'(bus.m_axi_awvalid), 64'd0);
        $display("[TB] txn dropped read packet");

        // reset in the middle of a transfer with AW stalled
        aw_delay = 50; w_delay = 50;
        bus.wr_packet = {32'h0, 32'h1234_5678, 32'h0000_8000, 5'd0, 2'd2, 1'b1};
        bus.wr_access = 1'b1;
        @(negedge clk);
        bus.wr_access = 1'b0;
        @(negedge clk);
        check("mid_awvalid_before_rst", 64'(bus.m_axi_awvalid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_awvalid", 64'(bus.m_axi_awvalid), 64'd0);
        check("mid_rst_wvalid", 64'(bus.m_axi_wvalid), 64'd0);
        check("mid_rst_bready", 64'(bus.m_axi_bready), 64'd0);
        check("mid_rst_wr_wait", 64'(bus.wr_wait), 64'd0);
        check("mid_rst_err_count", 64'(bus.err_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] txn reset mid-transfer");

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            dm = 2'($urandom_range(0, 3));
            send(dm, $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                 ($urandom_range(0, 5) == 0) ? 12'($urandom_range(0, 4095)) : AXI_ID);
        end

        // error counter saturation
        for (int i = 0; i < 300; i++) begin
            send(2'd2, 32'h0000_9000, 32'($urandom), 32'h0, 0, 0, 0, 2'b11, AXI_ID);
        end
        @(negedge clk);
        check("err_count_saturated", 64'(bus.err_count), 64'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
